// File: rtl/flt_pkg.sv
// flt_pkg: shared half-precision float definitions (state encoding, field widths, int16 limits)
package flt_pkg;
   typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, SHIFT, RND, WR_HI, WR_LO, DONE} state_t;
   localparam int          EXP_BIAS = 15;
   localparam int          EXP_W    = 5;
   localparam int          MANT_W   = 10;
   localparam logic [15:0] INT_MAX  = 16'h7FFF;
   localparam logic [15:0] INT_MIN  = 16'h8000;
endpackage

// File: rtl/flt2int_round.sv
// flt2int_round: round-half-even, sign apply and saturation of an aligned magnitude
//  m      in  16  aligned integer magnitude
//  guard  in   1  first bit shifted out below m
//  sticky in   1  OR of all bits shifted out below guard
//  sign   in   1  float sign
//  sat    in   1  exponent too large for int16
//  res    out 16  two's-complement int16 result
module flt2int_round
   import flt_pkg::*;
(
   input  logic [15:0] m,
   input  logic        guard,
   input  logic        sticky,
   input  logic        sign,
   input  logic        sat,
   output logic [15:0] res
);
   logic [15:0] mag;
   assign mag = m + {15'd0, guard & (sticky | m[0])};
   assign res = sat ? (sign ? INT_MIN : INT_MAX) : (sign ? -mag : mag);
endmodule

// File: rtl/flt2int_seq.sv
// flt2int_seq: multi-cycle half-precision float to int16 converter over a byte-wide data memory
//  clk          in   1  clock
//  reset        in   1  asynchronous active-low reset
//  start        in   1  conversion request, sampled in IDLE/DONE
//  done         out  1  conversion finished
//  busy         out  1  conversion in progress
//  DataAddress  out  8  memory address
//  ReadMem      out  1  memory read enable
//  WriteMem     out  1  memory write enable
//  DataIn       out  8  memory write data
//  DataOut      in   8  memory read data (combinational)
module flt2int_seq
   import flt_pkg::*;
#(
   parameter logic [7:0] SRC_ADDR = 8'd128,
   parameter logic [7:0] DST_ADDR = 8'd130
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic       busy,
   output logic [7:0] DataAddress,
   output logic       ReadMem,
   output logic       WriteMem,
   output logic [7:0] DataIn,
   input  logic [7:0] DataOut
);
   state_t            state, nxt;
   logic [7:0]        hi;
   logic [15:0]       m, res, rnd;
   logic              guard, sticky, left, sat;
   logic [3:0]        cnt, k_d;
   logic [EXP_W-1:0]  e;
   logic              zero_d, sat_d, left_d;

   // exponent decode happens in RD_LO, using the high byte captured in RD_HI
   assign e      = hi[6:2];
   assign zero_d = e <= 5'(EXP_BIAS - 2);
   assign sat_d  = e >= 5'(EXP_BIAS + 15);
   assign left_d = e >= 5'(EXP_BIAS + MANT_W);
   assign k_d    = (zero_d | sat_d) ? 4'd0 :
                   left_d ? 4'(e - 5'(EXP_BIAS + MANT_W)) : 4'(5'(EXP_BIAS + MANT_W) - e);

   flt2int_round u_round (
      .m      (m),
      .guard  (guard),
      .sticky (sticky),
      .sign   (hi[7]),
      .sat    (sat),
      .res    (rnd)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state  <= IDLE;
         hi     <= '0;
         m      <= '0;
         guard  <= 1'b0;
         sticky <= 1'b0;
         left   <= 1'b0;
         sat    <= 1'b0;
         cnt    <= '0;
         res    <= '0;
      end else begin
         state <= nxt;
         if (state == RD_HI) hi <= DataOut;
         if (state == RD_LO) begin
            m      <= zero_d ? 16'd0 : {5'd0, 1'b1, hi[1:0], DataOut};
            guard  <= 1'b0;
            sticky <= 1'b0;
            left   <= left_d;
            sat    <= sat_d;
            cnt    <= k_d;
         end
         if (state == SHIFT) begin
            m      <= left ? {m[14:0], 1'b0} : {1'b0, m[15:1]};
            guard  <= left ? 1'b0 : m[0];
            sticky <= sticky | guard;
            cnt    <= cnt - 4'd1;
         end
         if (state == RND) res <= rnd;
      end

   always_comb begin
      nxt         = state;
      busy        = 1'b1;
      done        = 1'b0;
      ReadMem     = 1'b0;
      WriteMem    = 1'b0;
      DataAddress = 8'd0;
      DataIn      = 8'd0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            nxt  = start ? RD_HI : IDLE;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            nxt  = start ? RD_HI : DONE;
         end
         RD_HI: begin
            ReadMem     = 1'b1;
            DataAddress = SRC_ADDR;
            nxt         = RD_LO;
         end
         RD_LO: begin
            ReadMem     = 1'b1;
            DataAddress = SRC_ADDR + 8'd1;
            nxt         = (k_d == 4'd0) ? RND : SHIFT;
         end
         SHIFT: nxt = (cnt == 4'd1) ? RND : SHIFT;
         RND:   nxt = WR_HI;
         WR_HI: begin
            WriteMem    = 1'b1;
            DataAddress = DST_ADDR;
            DataIn      = res[15:8];
            nxt         = WR_LO;
         end
         WR_LO: begin
            WriteMem    = 1'b1;
            DataAddress = DST_ADDR + 8'd1;
            DataIn      = res[7:0];
            nxt         = DONE;
         end
         default: nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_flt2int_seq.sv
// tb_flt2int_seq: directed scoreboard bench for flt2int_seq with a behavioural byte memory
module tb_flt2int_seq;
   logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic       done, busy, ReadMem, WriteMem;
   logic [7:0] DataAddress, DataIn, DataOut;
   logic [7:0] mem [256];
   logic       tb_we = 1'b0;
   logic [7:0] tb_addr = 8'd0, tb_data = 8'd0;
   logic [15:0] sb [$];
   int vectors = 0, errors = 0, wr_cnt = 0;

   always #5 clk = ~clk;

   assign DataOut = mem[DataAddress];

   always @(posedge clk)
      if (WriteMem) begin
         mem[DataAddress] <= DataIn;
         wr_cnt <= wr_cnt + 1;
      end else if (tb_we) mem[tb_addr] <= tb_data;

   flt2int_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .busy        (busy),
      .DataAddress (DataAddress),
      .ReadMem     (ReadMem),
      .WriteMem    (WriteMem),
      .DataIn      (DataIn),
      .DataOut     (DataOut)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_addr = a;
      tb_data = d;
      tb_we   = 1'b1;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask

   // pulse_at: edge count after which start is raised again for one cycle (0 = never)
   task automatic convert(input logic [15:0] f, input logic [15:0] e, input int lat, input int pulse_at);
      int n = 0;
      int w0;
      logic [15:0] x;
      poke(8'd128, f[15:8]);
      poke(8'd129, f[7:0]);
      sb.push_back(e);
      w0 = wr_cnt;
      @(negedge clk);
      start = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
         start = (n == pulse_at);
         if (n == 1) begin
            chk($sformatf("busy %h", f), 16'(busy), 16'd1);
            chk($sformatf("rdaddr %h", f), 16'(DataAddress), 16'd128);
         end
      end while (!done && n < 40);
      start = 1'b0;
      chk($sformatf("latency %h", f), 16'(n), 16'(lat));
      x = sb.pop_front();
      chk($sformatf("result %h", f), {mem[130], mem[131]}, x);
      chk($sformatf("writes %h", f), 16'(wr_cnt - w0), 16'd2);
   endtask

   initial begin
      #12;
      chk("rst done", 16'(done), 16'd0);
      chk("rst busy", 16'(busy), 16'd0);
      chk("rst rd", 16'(ReadMem), 16'd0);
      chk("rst wr", 16'(WriteMem), 16'd0);
      chk("rst addr", 16'(DataAddress), 16'd0);
      chk("rst din", 16'(DataIn), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      convert(16'h3C00, 16'h0001, 16, 0);
      repeat (3) @(posedge clk);
      #1 chk("done hold", 16'(done), 16'd1);
      convert(16'hC500, 16'hFFFB, 14, 0);
      convert(16'h4100, 16'h0002, 15, 0);
      convert(16'h4300, 16'h0004, 15, 0);
      convert(16'h3800, 16'h0000, 17, 0);
      convert(16'hC100, 16'hFFFE, 15, 0);
      convert(16'h3A01, 16'h0001, 17, 0);
      convert(16'h77FF, 16'h7FF0, 10, 0);
      convert(16'h7800, 16'h7FFF, 6, 0);
      convert(16'hF800, 16'h8000, 6, 0);
      convert(16'h0000, 16'h0000, 6, 0);
      convert(16'h8000, 16'h0000, 6, 0);
      convert(16'h3400, 16'h0000, 6, 0);
      convert(16'h6000, 16'h0200, 7, 0);
      convert(16'h6400, 16'h0400, 6, 0);
      convert(16'hC500, 16'hFFFB, 14, 4);
      // abort in the middle of the SHIFT phase
      poke(8'd130, 8'hAA);
      poke(8'd131, 8'h55);
      poke(8'd128, 8'hC5);
      poke(8'd129, 8'h00);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort done", 16'(done), 16'd0);
      chk("abort wr", 16'(WriteMem), 16'd0);
      chk("abort busy", 16'(busy), 16'd0);
      chk("abort addr", 16'(DataAddress), 16'd0);
      repeat (12) @(posedge clk);
      #1 chk("abort mem", {mem[130], mem[131]}, 16'hAA55);
      @(negedge clk);
      reset = 1'b1;
      convert(16'h3C00, 16'h0001, 16, 0);
      chk("sb empty", 16'(sb.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
